// File: rtl/mux_dff_arbiter_if.sv
// Bundle between requesters, the arbiter and the shared muxed flop.
// master = requester/resource side, slave = arbiter.
interface mux_dff_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int CNT_W = 8
);
    logic [NREQ-1:0]   req;
    logic [2*NREQ-1:0] req_op;
    logic [NREQ-1:0]   req_data;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   done;
    logic [NREQ-1:0]   err;
    logic              busy;
    logic [CNT_W-1:0]  err_cnt;
    logic              ff_d;
    logic              ff_sel;
    logic              ff_rst;
    logic              ff_q;

    modport master (
        output req, req_op, req_data, ff_q,
        input  grant, done, err, busy, err_cnt, ff_d, ff_sel, ff_rst
    );

    modport slave (
        input  req, req_op, req_data, ff_q,
        output grant, done, err, busy, err_cnt, ff_d, ff_sel, ff_rst
    );
endinterface

// File: rtl/mux_dff_arbiter.sv
// Round-robin arbiter sequencing LOAD0/LOAD1/CLEAR operations onto one shared
// muxed flop, with readback check and a saturating mismatch counter.
//
// state  | meaning
// IDLE   | waiting for any req; winner picked and resource driven at the edge
// DRIVE  | resource inputs valid; flop captures at the closing edge
// SETTLE | resource inputs back to 0; q sampled and checked at the closing edge
// RESP   | done/err pulse visible for this single cycle
module mux_dff_arbiter #(
    parameter int NREQ  = 4,
    parameter int CNT_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    mux_dff_arbiter_if.slave  bus
);
    localparam int IDX_W = $clog2(NREQ);

    localparam logic [1:0] OP_LOAD0 = 2'b00;
    localparam logic [1:0] OP_LOAD1 = 2'b01;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t              r_state;
    logic [NREQ-1:0]     r_grant;
    logic [NREQ-1:0]     r_done;
    logic [NREQ-1:0]     r_err;
    logic                r_busy;
    logic [CNT_W-1:0]    r_err_cnt;
    logic                r_ff_d;
    logic                r_ff_sel;
    logic                r_ff_rst;
    logic [IDX_W-1:0]    r_rr_ptr;
    logic [IDX_W-1:0]    r_idx;
    logic                r_exp;

    state_t              w_state_nxt;
    logic [NREQ-1:0]     w_grant_nxt;
    logic [NREQ-1:0]     w_done_nxt;
    logic [NREQ-1:0]     w_err_nxt;
    logic                w_busy_nxt;
    logic [CNT_W-1:0]    w_err_cnt_nxt;
    logic                w_ff_d_nxt;
    logic                w_ff_sel_nxt;
    logic                w_ff_rst_nxt;
    logic [IDX_W-1:0]    w_rr_ptr_nxt;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic                w_exp_nxt;

    logic                w_found;
    logic [IDX_W-1:0]    w_win;
    logic [1:0]          w_win_op;
    logic                w_win_data;

    // Rotating priority: scan rr_ptr+1, rr_ptr+2, ... wrapping at NREQ.
    always_comb begin
        int idx;
        idx     = 0;
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(r_rr_ptr) + k) % NREQ;
            if (!w_found && bus.req[idx]) begin
                w_found = 1'b1;
                w_win   = IDX_W'(idx);
            end
        end
    end

    assign w_win_op   = bus.req_op[2*w_win +: 2];
    assign w_win_data = bus.req_data[w_win];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_done_nxt    = r_done;
        w_err_nxt     = r_err;
        w_busy_nxt    = r_busy;
        w_err_cnt_nxt = r_err_cnt;
        w_ff_d_nxt    = r_ff_d;
        w_ff_sel_nxt  = r_ff_sel;
        w_ff_rst_nxt  = r_ff_rst;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_idx_nxt     = r_idx;
        w_exp_nxt     = r_exp;

        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_idx_nxt   = w_win;
                    w_grant_nxt = NREQ'(1) << w_win;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = DRIVE;
                    case (w_win_op)
                        OP_LOAD0: begin
                            w_ff_sel_nxt = 1'b0;
                            w_ff_d_nxt   = w_win_data;
                            w_ff_rst_nxt = 1'b0;
                            w_exp_nxt    = w_win_data;
                        end
                        OP_LOAD1: begin
                            w_ff_sel_nxt = 1'b1;
                            w_ff_d_nxt   = ~w_win_data;
                            w_ff_rst_nxt = 1'b0;
                            w_exp_nxt    = w_win_data;
                        end
                        default: begin
                            w_ff_sel_nxt = 1'b0;
                            w_ff_d_nxt   = 1'b0;
                            w_ff_rst_nxt = 1'b1;
                            w_exp_nxt    = 1'b0;
                        end
                    endcase
                end
            end
            DRIVE: begin
                w_ff_d_nxt   = 1'b0;
                w_ff_sel_nxt = 1'b0;
                w_ff_rst_nxt = 1'b0;
                w_state_nxt  = SETTLE;
            end
            SETTLE: begin
                w_done_nxt = r_grant;
                if (bus.ff_q != r_exp) begin
                    w_err_nxt = r_grant;
                    if (r_err_cnt != {CNT_W{1'b1}}) begin
                        w_err_cnt_nxt = r_err_cnt + CNT_W'(1);
                    end
                end
                w_rr_ptr_nxt = r_idx;
                w_state_nxt  = RESP;
            end
            RESP: begin
                w_grant_nxt = '0;
                w_done_nxt  = '0;
                w_err_nxt   = '0;
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_grant   <= '0;
            r_done    <= '0;
            r_err     <= '0;
            r_busy    <= 1'b0;
            r_err_cnt <= '0;
            r_ff_d    <= 1'b0;
            r_ff_sel  <= 1'b0;
            r_ff_rst  <= 1'b0;
            r_rr_ptr  <= IDX_W'(NREQ - 1);
            r_idx     <= '0;
            r_exp     <= 1'b0;
        end else begin
            r_grant   <= w_grant_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            r_busy    <= w_busy_nxt;
            r_err_cnt <= w_err_cnt_nxt;
            r_ff_d    <= w_ff_d_nxt;
            r_ff_sel  <= w_ff_sel_nxt;
            r_ff_rst  <= w_ff_rst_nxt;
            r_rr_ptr  <= w_rr_ptr_nxt;
            r_idx     <= w_idx_nxt;
            r_exp     <= w_exp_nxt;
        end
    end

    assign bus.grant   = r_grant;
    assign bus.done    = r_done;
    assign bus.err     = r_err;
    assign bus.busy    = r_busy;
    assign bus.err_cnt = r_err_cnt;
    assign bus.ff_d    = r_ff_d;
    assign bus.ff_sel  = r_ff_sel;
    assign bus.ff_rst  = r_ff_rst;

    a_grant_onehot0 : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        $onehot0(r_grant));
    a_done_granted : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        ((r_done | r_err) & ~r_grant) == '0);
    a_ff_rst_drive : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        r_ff_rst |-> (r_state == DRIVE));
endmodule

// File: tb/tb_mux_dff_arbiter.sv
// Directed bench for mux_dff_arbiter: reset, CLEAR/LOAD0/LOAD1, round-robin
// order, readback errors with counter saturation, mid-op reset, short req pulse.
module tb_mux_dff_arbiter;
    logic clk;
    logic rst_n;
    logic stuck;
    int   checks;
    int   errors;

    mux_dff_arbiter_if #(.NREQ(4), .CNT_W(8)) bus ();

    mux_dff_arbiter #(.NREQ(4), .CNT_W(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared muxed flop: sync active-high reset, sel inverts d; optional stuck-at-0.
    initial bus.ff_q = 1'b0;
    always @(posedge clk) begin
        if (bus.ff_rst || stuck) bus.ff_q <= 1'b0;
        else                     bus.ff_q <= bus.ff_sel ? ~bus.ff_d : bus.ff_d;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.req = '0; bus.req_op = '0; bus.req_data = '0; stuck = 1'b0;
        rst_n = 1'b0;
        #3;
        checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b want 0000", bus.grant); end
        checks++; if (bus.done !== 4'b0000) begin errors++; $display("FAIL reset_done got %b want 0000", bus.done); end
        checks++; if (bus.err !== 4'b0000) begin errors++; $display("FAIL reset_err got %b want 0000", bus.err); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt got %0d want 0", bus.err_cnt); end
        checks++; if ({bus.ff_d, bus.ff_sel, bus.ff_rst} !== 3'b000) begin errors++;
            $display("FAIL reset_ff got %b want 000", {bus.ff_d, bus.ff_sel, bus.ff_rst}); end
        tick();
        #2 rst_n = 1'b1;
    endtask

    task automatic test_clear();
        bus.req = 4'b0001; bus.req_op = 8'b0000_0010; bus.req_data = 4'b0000;
        tick();
        checks++; if (bus.grant !== 4'b0001) begin errors++; $display("FAIL clr_grant_drive got %b want 0001", bus.grant); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL clr_busy got %b want 1", bus.busy); end
        checks++; if ({bus.ff_rst, bus.ff_sel, bus.ff_d} !== 3'b100) begin errors++;
            $display("FAIL clr_ff_drive got %b want 100", {bus.ff_rst, bus.ff_sel, bus.ff_d}); end
        tick();
        checks++; if (bus.ff_rst !== 1'b0) begin errors++; $display("FAIL clr_ff_rst_settle got %b want 0", bus.ff_rst); end
        checks++; if (bus.done !== 4'b0000) begin errors++; $display("FAIL clr_done_early got %b want 0000", bus.done); end
        checks++; if (bus.grant !== 4'b0001) begin errors++; $display("FAIL clr_grant_settle got %b want 0001", bus.grant); end
        tick();
        checks++; if (bus.done !== 4'b0001) begin errors++; $display("FAIL clr_done got %b want 0001", bus.done); end
        checks++; if (bus.err !== 4'b0000) begin errors++; $display("FAIL clr_err got %b want 0000", bus.err); end
        checks++; if (bus.grant !== 4'b0001) begin errors++; $display("FAIL clr_grant_resp got %b want 0001", bus.grant); end
        bus.req = 4'b0000;
        tick();
        checks++; if ({bus.grant, bus.done, bus.busy} !== 9'd0) begin errors++;
            $display("FAIL clr_idle got %b want 0", {bus.grant, bus.done, bus.busy}); end
        checks++; if (bus.err_cnt !== 8'd0) begin errors++; $display("FAIL clr_err_cnt got %0d want 0", bus.err_cnt); end
    endtask

    task automatic test_load();
        bus.req = 4'b0010; bus.req_op = 8'b0000_0000; bus.req_data = 4'b0010;
        tick();
        checks++; if (bus.grant !== 4'b0010) begin errors++; $display("FAIL ld0_grant got %b want 0010", bus.grant); end
        checks++; if ({bus.ff_sel, bus.ff_d, bus.ff_rst} !== 3'b010) begin errors++;
            $display("FAIL ld0_ff got %b want 010", {bus.ff_sel, bus.ff_d, bus.ff_rst}); end
        tick();
        checks++; if ({bus.ff_sel, bus.ff_d} !== 2'b00) begin errors++;
            $display("FAIL ld0_ff_settle got %b want 00", {bus.ff_sel, bus.ff_d}); end
        tick();
        checks++; if (bus.done !== 4'b0010) begin errors++; $display("FAIL ld0_done got %b want 0010", bus.done); end
        checks++; if (bus.err !== 4'b0000) begin errors++; $display("FAIL ld0_err got %b want 0000", bus.err); end
        bus.req = 4'b0000;
        tick();
        bus.req = 4'b0010; bus.req_op = 8'b0000_0100; bus.req_data = 4'b0000;
        tick();
        checks++; if (bus.grant !== 4'b0010) begin errors++; $display("FAIL ld1_grant got %b want 0010", bus.grant); end
        checks++; if ({bus.ff_sel, bus.ff_d, bus.ff_rst} !== 3'b110) begin errors++;
            $display("FAIL ld1_ff got %b want 110", {bus.ff_sel, bus.ff_d, bus.ff_rst}); end
        tick();
        tick();
        checks++; if (bus.done !== 4'b0010) begin errors++; $display("FAIL ld1_done got %b want 0010", bus.done); end
        checks++; if (bus.err !== 4'b0000) begin errors++; $display("FAIL ld1_err got %b want 0000", bus.err); end
        bus.req = 4'b0000;
        tick();
        checks++; if (bus.err_cnt !== 8'd0) begin errors++; $display("FAIL ld_err_cnt got %0d want 0", bus.err_cnt); end
    endtask

    task automatic test_round_robin();
        logic [3:0] order [5];
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        bus.req = 4'b1111; bus.req_op = 8'b0000_0000; bus.req_data = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (bus.grant !== order[i]) begin errors++;
                $display("FAIL rr_grant[%0d] got %b want %b", i, bus.grant, order[i]); end
            tick();
            tick();
            checks++; if (bus.done !== order[i] || bus.err !== 4'b0000) begin errors++;
                $display("FAIL rr_done[%0d] got done=%b err=%b want done=%b err=0000", i, bus.done, bus.err, order[i]); end
            tick();
            checks++; if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin errors++;
                $display("FAIL rr_idle[%0d] got grant=%b busy=%b want 0000/0", i, bus.grant, bus.busy); end
        end
        bus.req = 4'b0000;
        tick();
    endtask

    task automatic test_err_sat();
        do_reset();
        stuck = 1'b1;
        bus.req = 4'b0100; bus.req_op = 8'b0000_0000; bus.req_data = 4'b0100;
        tick();
        checks++; if (bus.grant !== 4'b0100) begin errors++; $display("FAIL err_grant got %b want 0100", bus.grant); end
        tick();
        tick();
        checks++; if (bus.done !== 4'b0100) begin errors++; $display("FAIL err_done got %b want 0100", bus.done); end
        checks++; if (bus.err !== 4'b0100) begin errors++; $display("FAIL err_err got %b want 0100", bus.err); end
        checks++; if (bus.err_cnt !== 8'd1) begin errors++; $display("FAIL err_cnt1 got %0d want 1", bus.err_cnt); end
        tick();
        for (int i = 1; i < 300; i++) begin
            tick(); tick(); tick(); tick();
            if (i == 254) begin
                checks++; if (bus.err_cnt !== 8'd255) begin errors++;
                    $display("FAIL err_cnt255 got %0d want 255", bus.err_cnt); end
            end
        end
        bus.req = 4'b0000;
        checks++; if (bus.err_cnt !== 8'd255) begin errors++; $display("FAIL err_cnt_sat got %0d want 255", bus.err_cnt); end
        tick();
        stuck = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.req = 4'b0001; bus.req_op = 8'b0000_0000; bus.req_data = 4'b0001;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({bus.grant, bus.done, bus.err, bus.busy} !== 13'd0) begin errors++;
            $display("FAIL mid_rst_outs got %b want 0", {bus.grant, bus.done, bus.err, bus.busy}); end
        checks++; if (bus.err_cnt !== 8'd0) begin errors++; $display("FAIL mid_rst_err_cnt got %0d want 0", bus.err_cnt); end
        bus.req = 4'b0000;
        tick();
        checks++; if (bus.done !== 4'b0000) begin errors++; $display("FAIL mid_rst_done got %b want 0000", bus.done); end
        #2 rst_n = 1'b1;
        bus.req = 4'b1001; bus.req_op = 8'b0000_0000; bus.req_data = 4'b1001;
        tick();
        checks++; if (bus.grant !== 4'b0001) begin errors++; $display("FAIL mid_first_grant got %b want 0001", bus.grant); end
        tick();
        tick();
        checks++; if (bus.done !== 4'b0001) begin errors++; $display("FAIL mid_first_done got %b want 0001", bus.done); end
        bus.req = 4'b1000;
        tick();
        tick();
        checks++; if (bus.grant !== 4'b1000) begin errors++; $display("FAIL mid_second_grant got %b want 1000", bus.grant); end
        tick();
        tick();
        checks++; if (bus.done !== 4'b1000) begin errors++; $display("FAIL mid_second_done got %b want 1000", bus.done); end
        bus.req = 4'b0000;
        tick();
    endtask

    task automatic test_pulse();
        bus.req = 4'b1000; bus.req_op = 8'b0100_0000; bus.req_data = 4'b0000;
        tick();
        checks++; if (bus.grant !== 4'b1000) begin errors++; $display("FAIL pulse_grant got %b want 1000", bus.grant); end
        checks++; if ({bus.ff_sel, bus.ff_d} !== 2'b11) begin errors++;
            $display("FAIL pulse_ff got %b want 11", {bus.ff_sel, bus.ff_d}); end
        bus.req = 4'b0000;
        tick();
        tick();
        checks++; if (bus.done !== 4'b1000 || bus.err !== 4'b0000) begin errors++;
            $display("FAIL pulse_done got done=%b err=%b want 1000/0000", bus.done, bus.err); end
        tick();
        checks++; if ({bus.grant, bus.done, bus.busy} !== 9'd0) begin errors++;
            $display("FAIL pulse_idle got %b want 0", {bus.grant, bus.done, bus.busy}); end
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL pulse_no_retrigger got %b want 0", bus.busy); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_clear();
        test_load();
        test_round_robin();
        test_err_sat();
        test_reset_mid();
        test_pulse();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
